dsm_stereo_decimator: RTL and testbench
=======================================

// Module: dsm_stereo_decimator
// PURPOSE
//  Receive side of the stereo delta-sigma link: turns two 1-bit DSM/PDM streams
//  (one bit per clk per channel) back into unsigned PCM.
//  Each channel uses a 2nd-order CIC (sinc^2) decimator, decimating by R = 2**DECIM_LOG2.
//  Sits after the dsm_stereo outputs (or an external PDM source) and feeds PCM consumers
//  through a single-cycle valid strobe.
// PARAMETERS
//  PCM_WIDTH  12  output PCM width, unsigned; full scale = 2**PCM_WIDTH-1
//  DECIM_LOG2 6   log2 of decimation ratio R; must satisfy 2*DECIM_LOG2 >= PCM_WIDTH
// PORTS
//  clk        in   1          system clock; one DSM bit per channel per rising edge
//  aclr       in   1          reset, synchronous, active-high
//  left_in    in   1          left DSM bitstream; 1 = high density
//  right_in   in   1          right DSM bitstream
//  left_pcm   out  PCM_WIDTH  left decimated sample, held between strobes
//  right_pcm  out  PCM_WIDTH  right decimated sample, held between strobes
//  pcm_valid  out  1          one-cycle strobe: left_pcm/right_pcm updated this cycle
// BEHAVIOUR
//  - Reset (aclr=1 at clk edge):
//    - integrators, comb delays, phase counter and warm-up counter cleared;
//      left_pcm=0, right_pcm=0, pcm_valid=0.
//    - Reset asserted mid-frame discards the partial frame; warm-up restarts.
//  - Accumulator width AW = 2*DECIM_LOG2+1. All integrator/comb arithmetic is modulo 2**AW.
//    Wrap-around is intended and must not saturate.
//  - Every cycle, per channel: i1 <= i1 + in_bit; i2 <= i2 + i1_next.
//    i1_next includes the current bit.
//  - phase: 0..R-1 counter, shared by both channels; increments every cycle, wraps R-1 -> 0.
//  - On the cycle phase==R-1, per channel:
//    s = i2_next; c1 = s - s_d; c2 = c1 - c1_d; s_d <= s; c1_d <= c1.
//  - Output scaling: y = c2 >> (2*DECIM_LOG2 - PCM_WIDTH), range 0..2**PCM_WIDTH inclusive.
//    y == 2**PCM_WIDTH saturates to 2**PCM_WIDTH-1. No other clipping.
//  - Output timing:
//    - left_pcm/right_pcm register y on the edge ending the phase==R-1 cycle.
//    - pcm_valid is high for exactly the following cycle.
//    - Strobe period is exactly R cycles.
//  - Warm-up: the first 2 decimation frames after reset are transients.
//    - Their strobes are suppressed: pcm_valid stays 0 and pcm holds 0.
//    - First pcm_valid appears in cycle 3R after reset deassertion.
//      Cycle 0 is the first cycle with aclr=0.
//  - Steady state: kernel is a triangle of length 2R-1 with gain R^2.
//    Constant bit density d gives y = d*2**PCM_WIDTH exactly when d*R is an integer.
//  - Channels are fully independent apart from the shared phase/warm-up counters.
//    Identical inputs give bit-identical outputs on both channels.
// STRUCTURE
//  - dsm_pkg holds:
//    - accumulator-width function acc_width(DECIM_LOG2);
//    - output shift constant;
//    - saturation constant PCM_MAX.
//    dsm_stereo shares this package.
//  - Sub-module dsm_cic2_channel: i1, i2, s_d, c1_d, scale+saturate, pcm register.
//    Inputs: clk, aclr, in_bit, dump (phase==R-1).
//    Instantiated twice, for left and right.
//  - Top level holds: phase counter, 2-bit warm-up counter, pcm_valid generation.
// TESTING
//  1. Both inputs 0 forever -> every pcm_valid shows left_pcm=right_pcm=0.
//     Strobes every 64 clk; first strobe at cycle 192.
//  2. Both inputs 1 forever -> raw value 4096 saturates; left_pcm=right_pcm=4095 on every strobe.
//  3. left=1010..., right=1000... repeating -> left_pcm=2048, right_pcm=1024.
//     Both exact, independent of start phase.
//  4. Loopback from dsm_stereo (PCM_WIDTH=12):
//     - left pcm 127, right 1024, then left 2048 / right 3750;
//     - each held 4096 clk;
//     - after 3 strobes of settling, outputs within +/-2 LSB of the driven values.
//  5. aclr pulsed for 1 cycle mid-frame (phase=30) with inputs all 1 ->
//     - next cycle: pcm=0, valid=0;
//     - no strobe for 191 cycles;
//     - first strobe at cycle 192 after release, value 4095.
//  6. Long run of 2**AW+ cycles of all-ones -> integrator wrap is invisible; output stays 4095.
//     Then switch to 1010... -> 2048 from the third strobe after the switch.

Source files
------------

// File: rtl/dsm_pkg.sv
// Shared constants and helpers for the stereo delta-sigma link (modulator and decimator).
// Widths are derived from the decimation ratio so both ends agree on the arithmetic.
package dsm_pkg;

  localparam int PCM_WIDTH_DEFAULT  = 12;
  localparam int DECIM_LOG2_DEFAULT = 6;

  // sinc^2 gain is R^2 = 2**(2*DECIM_LOG2); one extra bit holds the full-scale value.
  function automatic int acc_width(input int decim_log2);
    return 2 * decim_log2 + 1;
  endfunction

  function automatic int out_shift(input int decim_log2, input int pcm_width);
    return 2 * decim_log2 - pcm_width;
  endfunction

  function automatic int pcm_max(input int pcm_width);
    return (1 << pcm_width) - 1;
  endfunction

  localparam int PCM_MAX = (1 << PCM_WIDTH_DEFAULT) - 1;

  typedef enum logic [1:0] {
    WARM_FRAME0 = 2'd0,
    WARM_FRAME1 = 2'd1,
    WARM_DONE   = 2'd2
  } warm_e;

endpackage

// File: rtl/dsm_cic2_channel.sv
// One channel of the sinc^2 decimator: two integrators at the bit rate, two combs
// at the frame rate, then scale, saturate and hold the PCM sample.
module dsm_cic2_channel
  import dsm_pkg::*;
#(
  parameter int PCM_WIDTH  = PCM_WIDTH_DEFAULT,
  parameter int DECIM_LOG2 = DECIM_LOG2_DEFAULT
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 in_bit,
  input  logic                 dump,
  input  logic                 pcm_en,
  output logic [PCM_WIDTH-1:0] pcm
);

  localparam int AW    = acc_width(DECIM_LOG2);
  localparam int SHIFT = out_shift(DECIM_LOG2, PCM_WIDTH);
  localparam logic [PCM_WIDTH-1:0] SAT_VAL = PCM_WIDTH'(pcm_max(PCM_WIDTH));

  logic [AW-1:0]        i1_q, i1_d;
  logic [AW-1:0]        i2_q, i2_d;
  logic [AW-1:0]        s_d_q, s_d_d;
  logic [AW-1:0]        c1_d_q, c1_d_d;
  logic [AW-1:0]        c1, c2, y_wide;
  logic [PCM_WIDTH:0]   y;
  logic [PCM_WIDTH-1:0] pcm_q, pcm_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    s_d_d  = s_d_q;
    c1_d_d = c1_d_q;
    pcm_d  = pcm_q;

    // Integrators and combs wrap modulo 2**AW; the differences cancel the wrap exactly.
    i1_d   = i1_q + AW'(in_bit);
    i2_d   = i2_q + i1_d;
    c1     = i2_d - s_d_q;
    c2     = c1 - c1_d_q;
    y_wide = c2 >> SHIFT;
    y      = y_wide[PCM_WIDTH:0];

    if (dump) begin
      s_d_d  = i2_d;
      c1_d_d = c1;
      if (pcm_en) begin
        pcm_d = y[PCM_WIDTH] ? SAT_VAL : y[PCM_WIDTH-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (aclr) begin
      i1_q   <= '0;
      i2_q   <= '0;
      s_d_q  <= '0;
      c1_d_q <= '0;
      pcm_q  <= '0;
    end else begin
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      s_d_q  <= s_d_d;
      c1_d_q <= c1_d_d;
      pcm_q  <= pcm_d;
    end
  end

  assign pcm = pcm_q;

endmodule

// File: rtl/dsm_stereo_decimator.sv
// Stereo sinc^2 decimator: shared frame phase and warm-up tracking around two
// independent channel filters, with a one-cycle valid strobe per output frame.
module dsm_stereo_decimator
  import dsm_pkg::*;
#(
  parameter int PCM_WIDTH  = PCM_WIDTH_DEFAULT,
  parameter int DECIM_LOG2 = DECIM_LOG2_DEFAULT
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 left_in,
  input  logic                 right_in,
  output logic [PCM_WIDTH-1:0] left_pcm,
  output logic [PCM_WIDTH-1:0] right_pcm,
  output logic                 pcm_valid
);

  logic [DECIM_LOG2-1:0] phase_q, phase_d;
  warm_e                 warm_q, warm_d;
  logic                  valid_q, valid_d;
  logic                  dump;
  logic                  pcm_en;

  always_comb begin
    warm_d  = warm_q;
    dump    = (phase_q == '1);
    phase_d = phase_q + DECIM_LOG2'(1);
    // The first two frames see an incomplete triangle kernel; their results are dropped.
    pcm_en  = dump && (warm_q == WARM_DONE);
    valid_d = pcm_en;

    if (dump) begin
      case (warm_q)
        WARM_FRAME0: warm_d = WARM_FRAME1;
        WARM_FRAME1: warm_d = WARM_DONE;
        default:     warm_d = WARM_DONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      phase_q <= '0;
      warm_q  <= WARM_FRAME0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      warm_q  <= warm_d;
      valid_q <= valid_d;
    end
  end

  dsm_cic2_channel #(
    .PCM_WIDTH  (PCM_WIDTH),
    .DECIM_LOG2 (DECIM_LOG2)
  ) u_left (
    .clk    (clk),
    .aclr   (aclr),
    .in_bit (left_in),
    .dump   (dump),
    .pcm_en (pcm_en),
    .pcm    (left_pcm)
  );

  dsm_cic2_channel #(
    .PCM_WIDTH  (PCM_WIDTH),
    .DECIM_LOG2 (DECIM_LOG2)
  ) u_right (
    .clk    (clk),
    .aclr   (aclr),
    .in_bit (right_in),
    .dump   (dump),
    .pcm_en (pcm_en),
    .pcm    (right_pcm)
  );

  assign pcm_valid = valid_q;

endmodule

// File: tb/tb_dsm_stereo_decimator.sv
// Directed bench for dsm_stereo_decimator: periodic bit patterns with exact
// expected PCM values, strobe timing checked on every cycle.
module tb_dsm_stereo_decimator;

  localparam int PCM_WIDTH  = 12;
  localparam int DECIM_LOG2 = 6;
  localparam int R          = 1 << DECIM_LOG2;
  localparam int FIRST      = 3 * R;
  localparam int NO_SWITCH  = 1 << 30;

  logic                 clk = 1'b0;
  logic                 aclr = 1'b1;
  logic                 left_in = 1'b0;
  logic                 right_in = 1'b0;
  logic [PCM_WIDTH-1:0] left_pcm;
  logic [PCM_WIDTH-1:0] right_pcm;
  logic                 pcm_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dsm_stereo_decimator #(
    .PCM_WIDTH  (PCM_WIDTH),
    .DECIM_LOG2 (DECIM_LOG2)
  ) dut (
    .clk       (clk),
    .aclr      (aclr),
    .left_in   (left_in),
    .right_in  (right_in),
    .left_pcm  (left_pcm),
    .right_pcm (right_pcm),
    .pcm_valid (pcm_valid)
  );

  // Patterns repeat every 4 cycles; bit [t%4] is driven in cycle t.
  typedef struct {
    string      name;
    logic [3:0] lpat;
    logic [3:0] rpat;
    int         exp_l;
    int         exp_r;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reset, then drive pattern 1 until cycle sw and pattern 2 afterwards.
  // Strobes at or before sw expect (el1,er1); from the third strobe after sw, (el2,er2).
  task automatic run(input string name,
                     input logic [3:0] lp1, input logic [3:0] rp1, input int el1, input int er1,
                     input int sw,
                     input logic [3:0] lp2, input logic [3:0] rp2, input int el2, input int er2,
                     input int ncyc);
    int  after_sw = 0;
    bit  known = 1'b1;
    int  el = 0;
    int  er = 0;
    bit  exp_v;
    aclr = 1'b1;
    @(posedge clk);
    #1;
    check({name, " reset valid"}, 32'(pcm_valid), 0);
    check({name, " reset left"},  32'(left_pcm),  0);
    check({name, " reset right"}, 32'(right_pcm), 0);
    aclr = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      left_in  = (t < sw) ? lp1[t % 4] : lp2[t % 4];
      right_in = (t < sw) ? rp1[t % 4] : rp2[t % 4];
      @(posedge clk);
      #1;
      exp_v = ((t + 1) >= FIRST) && (((t + 1) % R) == 0);
      check($sformatf("%s valid@%0d", name, t + 1), 32'(pcm_valid), 32'(exp_v));
      if (exp_v) begin
        if ((t + 1) <= sw) begin
          known = 1'b1;
          el = el1;
          er = er1;
        end else begin
          after_sw++;
          if (after_sw >= 3) begin
            known = 1'b1;
            el = el2;
            er = er2;
          end else begin
            known = 1'b0;
          end
        end
      end
      if (known) begin
        check($sformatf("%s left@%0d", name, t + 1),  32'(left_pcm),  el);
        check($sformatf("%s right@%0d", name, t + 1), 32'(right_pcm), er);
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"zeros",      4'b0000, 4'b0000,    0,    0};
    vecs[1] = '{"ones",       4'b1111, 4'b1111, 4095, 4095};
    vecs[2] = '{"half_qtr",   4'b0101, 4'b0001, 2048, 1024};
    vecs[3] = '{"3q_zero",    4'b0111, 4'b0000, 3072,    0};
    vecs[4] = '{"zero_ones",  4'b0000, 4'b1111,    0, 4095};
    vecs[5] = '{"half_3q",    4'b0011, 4'b1110, 2048, 3072};

    for (int i = 0; i < 6; i++) begin
      run(vecs[i].name, vecs[i].lpat, vecs[i].rpat, vecs[i].exp_l, vecs[i].exp_r,
          NO_SWITCH, 4'b0000, 4'b0000, 0, 0, FIRST + 2 * R + 10);
    end

    // Mid-frame reset: run to phase 30 with all ones, then restart from scratch.
    run("pre_abort", 4'b1111, 4'b1111, 4095, 4095, NO_SWITCH,
        4'b0000, 4'b0000, 0, 0, FIRST + 30);
    run("post_abort", 4'b1111, 4'b1111, 4095, 4095, NO_SWITCH,
        4'b0000, 4'b0000, 0, 0, FIRST + 2 * R + 10);

    // Integrators wrap many times over 2**13 cycles; then switch patterns mid-frame.
    run("wrap_switch", 4'b1111, 4'b1111, 4095, 4095, 8500,
        4'b0101, 4'b0001, 2048, 1024, 8500 + 5 * R);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
